// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: accepts a byte stream, serialises it into an external
// bit-serial CRC engine, then collects the engine's 8-bit result and
// presents it on CRC_Out with a one-cycle CRC_Done strobe.
module crc_frame_ctrl #(
    parameter bit LSB_FIRST = 1'b1,
    parameter int MAX_BYTES = 255
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [7:0] In_Data,
    input  logic       In_Valid,
    input  logic       In_Last,
    output logic       In_Ready,
    output logic       Eng_Rst_n,
    output logic       Eng_Active,
    output logic       Eng_Data,
    input  logic       Eng_CRC,
    output logic [7:0] CRC_Out,
    output logic       CRC_Done,
    output logic       Err,
    output logic       Busy
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SHIFT,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic       last_reg;
    logic [7:0] byte_cnt_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] hold_reg;
    logic [7:0] hold_next;
    logic [7:0] crc_out_reg;
    logic       err_reg;

    logic       byte_end;
    logic       more_ok;
    logic       load_next;
    logic       underrun;

    // Last bit of the current byte is on the wire this cycle.
    assign byte_end  = (state_reg == ST_SHIFT) && (bit_cnt_reg == 3'd7);
    // Another byte may follow only if the frame is not closed and not full.
    assign more_ok   = !last_reg && (byte_cnt_reg != MAX_CNT);
    assign load_next = byte_end && more_ok && In_Valid;
    // Frame expected more data but none arrived (or the length cap was hit).
    assign underrun  = byte_end && !last_reg && !load_next;

    assign shift_next = LSB_FIRST ? {1'b0, shift_reg[7:1]} : {shift_reg[6:0], 1'b0};

    // Engine result arrives one bit per CAPTURE cycle; bit k lands in slot k.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_hold
            assign hold_next[gi] = ((state_reg == ST_CAPTURE) && (bit_cnt_reg == 3'(gi)))
                                   ? Eng_CRC : hold_reg[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (In_Valid) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (byte_end) begin
                    if (last_reg) begin
                        state_next = ST_WAIT;
                    end else if (load_next) begin
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_WAIT: state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                if (bit_cnt_reg == 3'd7) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode; Reset forces the engine into clear and hides all status.
    always_comb begin
        In_Ready   = 1'b0;
        Eng_Rst_n  = 1'b0;
        Eng_Active = 1'b0;
        Eng_Data   = 1'b0;
        Busy       = 1'b0;
        CRC_Done   = 1'b0;
        if (!Reset) begin
            Busy       = (state_reg != ST_IDLE);
            Eng_Rst_n  = (state_reg != ST_CLEAR);
            Eng_Active = (state_reg == ST_SHIFT);
            Eng_Data   = (state_reg == ST_SHIFT) &&
                         (LSB_FIRST ? shift_reg[0] : shift_reg[7]);
            In_Ready   = (state_reg == ST_IDLE) || (byte_end && more_ok);
            CRC_Done   = (state_reg == ST_DONE);
        end
    end

    // Datapath: byte loading, bit/byte counting, result capture, error strobe.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            shift_reg    <= 8'h00;
            last_reg     <= 1'b0;
            byte_cnt_reg <= 8'h00;
            bit_cnt_reg  <= 3'd0;
            hold_reg     <= 8'h00;
            crc_out_reg  <= 8'h00;
            err_reg      <= 1'b0;
        end else begin
            err_reg  <= underrun;
            hold_reg <= hold_next;
            case (state_reg)
                ST_IDLE: begin
                    if (In_Valid) begin
                        shift_reg    <= In_Data;
                        last_reg     <= In_Last;
                        byte_cnt_reg <= 8'd1;
                        bit_cnt_reg  <= 3'd0;
                    end
                end
                ST_CLEAR: bit_cnt_reg <= 3'd0;
                ST_SHIFT: begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (load_next) begin
                        shift_reg    <= In_Data;
                        last_reg     <= In_Last;
                        byte_cnt_reg <= byte_cnt_reg + 8'd1;
                    end else begin
                        shift_reg <= shift_next;
                    end
                end
                ST_WAIT: bit_cnt_reg <= 3'd0;
                ST_CAPTURE: begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        crc_out_reg <= hold_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign CRC_Out = crc_out_reg;
    assign Err     = err_reg;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: two instances (default, and MSB-first with a
// two-byte cap), each paired with a behavioural CRC-8 (poly 0x07) engine.
module tb_crc_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data  [2];
    logic       in_valid [2];
    logic       in_last  [2];
    logic       in_ready [2];
    logic       eng_rst_n [2];
    logic       eng_active [2];
    logic       eng_data [2];
    logic       eng_crc [2];
    logic [7:0] crc_out [2];
    logic       crc_done [2];
    logic       err [2];
    logic       busy [2];

    logic [7:0] lfsr [2];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int sel      = 0;

    bit bit_q[$];
    int done_cnt = 0, err_cnt = 0, rstn_low = 0, done_cyc = 0, err_cyc = 0;
    int d0, e0, b0, r0, acc_cyc, acc;
    logic [7:0] frame_bytes [4];
    logic [7:0] crc_t2;

    always #5 clk = ~clk;

    crc_frame_ctrl u_dut (
        .CLK(clk), .Reset(reset),
        .In_Data(in_data[0]), .In_Valid(in_valid[0]), .In_Last(in_last[0]),
        .In_Ready(in_ready[0]), .Eng_Rst_n(eng_rst_n[0]), .Eng_Active(eng_active[0]),
        .Eng_Data(eng_data[0]), .Eng_CRC(eng_crc[0]), .CRC_Out(crc_out[0]),
        .CRC_Done(crc_done[0]), .Err(err[0]), .Busy(busy[0])
    );

    crc_frame_ctrl #(.LSB_FIRST(1'b0), .MAX_BYTES(2)) u_alt (
        .CLK(clk), .Reset(reset),
        .In_Data(in_data[1]), .In_Valid(in_valid[1]), .In_Last(in_last[1]),
        .In_Ready(in_ready[1]), .Eng_Rst_n(eng_rst_n[1]), .Eng_Active(eng_active[1]),
        .Eng_Data(eng_data[1]), .Eng_CRC(eng_crc[1]), .CRC_Out(crc_out[1]),
        .CRC_Done(crc_done[1]), .Err(err[1]), .Busy(busy[1])
    );

    function automatic logic [7:0] crc_step(input logic [7:0] l, input logic d);
        logic fb;
        fb = l[7] ^ d;
        return {l[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    function automatic logic [7:0] crc_model(input int n, input bit lsb);
        logic [7:0] l;
        l = 8'h00;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++)
                l = crc_step(l, lsb ? frame_bytes[i][j] : frame_bytes[i][7-j]);
        return l;
    endfunction

    function automatic logic [31:0] pack_bits(input int base, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < n; k++)
            if (base + k < bit_q.size()) v[k] = bit_q[base + k];
        return v;
    endfunction

    // Behavioural engine: absorbs while Active, otherwise shifts LSB out registered.
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!eng_rst_n[s]) begin
                lfsr[s]    <= 8'h00;
                eng_crc[s] <= 1'b0;
            end else if (eng_active[s]) begin
                lfsr[s] <= crc_step(lfsr[s], eng_data[s]);
            end else begin
                eng_crc[s] <= lfsr[s][0];
                lfsr[s]    <= {1'b0, lfsr[s][7:1]};
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the selected instance mid-cycle.
    always @(negedge clk) begin
        if (eng_active[sel]) bit_q.push_back(eng_data[sel]);
        if (crc_done[sel]) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
        if (err[sel]) begin err_cnt = err_cnt + 1; err_cyc = cyc; end
        if (!reset && !eng_rst_n[sel]) rstn_low = rstn_low + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    task automatic snap();
        d0 = done_cnt; e0 = err_cnt; b0 = bit_q.size(); r0 = rstn_low;
    endtask

    // Offer n bytes; stops offering when a byte is not taken within its window.
    task automatic send_frame(input int s, input int n, input bit with_last, output int nacc);
        int  lim;
        bit  got;
        nacc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_data[s]  = frame_bytes[i];
            in_last[s]  = with_last && (i == n - 1);
            in_valid[s] = 1'b1;
            lim = (i == 0) ? 1 : ((i == 1) ? 9 : 8);
            got = 1'b0;
            for (int w = 0; w < lim; w++) begin
                if (in_ready[s]) begin
                    got = 1'b1;
                    break;
                end
                if (w < lim - 1) @(negedge clk);
            end
            if (!got) break;
            if (i == 0) acc_cyc = cyc;
            @(posedge clk);
            #1;
            nacc++;
        end
        in_valid[s] = 1'b0;
        in_last[s]  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            in_data[s] = 8'h00; in_valid[s] = 1'b0; in_last[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready[0], 0);
        check("rst_eng_rst_n", eng_rst_n[0], 0);
        check("rst_eng_active", eng_active[0], 0);
        check("rst_eng_data", eng_data[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_crc_out", crc_out[0], 0);
        check("rst_done_err", {crc_done[0], err[0]}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", in_ready[0], 1);
        check("idle_rst_n", eng_rst_n[0], 1);

        // Single zero byte.
        frame_bytes[0] = 8'h00;
        snap();
        send_frame(0, 1, 1'b1, acc);
        repeat (25) @(negedge clk);
        check("t1_acc", acc, 1);
        check("t1_done", done_cnt - d0, 1);
        check("t1_err", err_cnt - e0, 0);
        check("t1_lat", done_cyc - acc_cyc, 19);
        check("t1_nbits", bit_q.size() - b0, 8);
        check("t1_bits", pack_bits(b0, 8), 32'h0);
        check("t1_crc", crc_out[0], 8'h00);
        check("t1_clear_len", rstn_low - r0, 1);
        check("t1_busy", busy[0], 0);

        // Three bytes back to back, LSB first.
        frame_bytes[0] = 8'hA5; frame_bytes[1] = 8'h3C; frame_bytes[2] = 8'hFF;
        crc_t2 = crc_model(3, 1'b1);
        snap();
        send_frame(0, 3, 1'b1, acc);
        repeat (30) @(negedge clk);
        check("t2_acc", acc, 3);
        check("t2_done", done_cnt - d0, 1);
        check("t2_lat", done_cyc - acc_cyc, 35);
        check("t2_nbits", bit_q.size() - b0, 24);
        check("t2_bits", pack_bits(b0, 24), 32'h00FF3CA5);
        check("t2_crc", crc_out[0], crc_t2);

        // Underrun after first byte of a two-byte frame.
        frame_bytes[0] = 8'h12;
        snap();
        send_frame(0, 1, 1'b0, acc);
        repeat (20) @(negedge clk);
        check("t3_err", err_cnt - e0, 1);
        check("t3_err_time", err_cyc - acc_cyc, 10);
        check("t3_done", done_cnt - d0, 0);
        check("t3_crc_kept", crc_out[0], crc_t2);
        check("t3_busy", busy[0], 0);

        // Reset in CAPTURE cycle 4.
        frame_bytes[0] = 8'h5A;
        snap();
        send_frame(0, 1, 1'b1, acc);
        for (int i = 0; i < 40 && cyc != acc_cyc + 15; i++) @(negedge clk);
        check("t4_at_cap4", cyc - acc_cyc, 15);
        check("t4_busy_cap", busy[0], 1);
        reset = 1'b1;
        @(negedge clk);
        check("t4_crc_clr", crc_out[0], 8'h00);
        check("t4_rst_n", eng_rst_n[0], 0);
        check("t4_busy", busy[0], 0);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_no_err", err_cnt - e0, 0);

        frame_bytes[0] = 8'h00;
        snap();
        send_frame(0, 1, 1'b1, acc);
        repeat (25) @(negedge clk);
        check("t4b_done", done_cnt - d0, 1);
        check("t4b_lat", done_cyc - acc_cyc, 19);
        check("t4b_crc", crc_out[0], 8'h00);

        // MSB-first instance: 0x80 -> engine sees 1 then seven 0s, CRC-8 = 0x89.
        sel = 1;
        @(negedge clk);
        frame_bytes[0] = 8'h80;
        snap();
        send_frame(1, 1, 1'b1, acc);
        repeat (25) @(negedge clk);
        check("t6_done", done_cnt - d0, 1);
        check("t6_lat", done_cyc - acc_cyc, 19);
        check("t6_bits", pack_bits(b0, 8), 32'h01);
        check("t6_crc", crc_out[1], 8'h89);

        // Length cap of two: third byte refused, frame aborted.
        frame_bytes[0] = 8'h11; frame_bytes[1] = 8'h22; frame_bytes[2] = 8'h33;
        snap();
        send_frame(1, 3, 1'b0, acc);
        repeat (20) @(negedge clk);
        check("t5_acc", acc, 2);
        check("t5_err", err_cnt - e0, 1);
        check("t5_err_time", err_cyc - acc_cyc, 18);
        check("t5_done", done_cnt - d0, 0);
        check("t5_crc_kept", crc_out[1], 8'h89);
        check("t5_busy", busy[1], 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/crc_frame_ctrl.md
CRC_FRAME_CTRL -- requirements
Module: crc_frame_ctrl

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1, meaning each byte is serialised bit 0 first (0 = bit 7 first).
REQ-002 SHALL have parameter MAX_BYTES, default 255, meaning the maximum frame length in bytes (1..255).
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port In_Data  input  8  frame byte.
REQ-006 SHALL have port In_Valid  input  1  In_Data/In_Last valid.
REQ-007 SHALL have port In_Last  input  1  byte is final byte of frame.
REQ-008 SHALL have port In_Ready  output  1  byte accepted on edge where In_Valid&In_Ready.
REQ-009 SHALL have port Eng_Rst_n  output  1  active-low clear to CRC engine.
REQ-010 SHALL have port Eng_Active  output  1  CRC engine Active (1 = absorb bit, 0 = shift CRC out).
REQ-011 SHALL have port Eng_Data  output  1  serial data bit to CRC engine.
REQ-012 SHALL have port Eng_CRC  input  1  serial CRC bit from engine, registered in engine, LSB first.
REQ-013 SHALL have port CRC_Out  output  8  captured frame CRC, held until next capture.
REQ-014 SHALL have port CRC_Done  output  1  one-cycle pulse, CRC_Out updated.
REQ-015 SHALL have port Err  output  1  one-cycle pulse, frame aborted.
REQ-016 SHALL have port Busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, CLEAR, SHIFT, WAIT, CAPTURE, DONE; Busy, Eng_Active, Eng_Rst_n, In_Ready decode state/counters without extra register delay.
REQ-018 IDLE: In_Ready=1; on In_Valid, SHALL load In_Data into an 8-bit shift register, latch In_Last, set byte count to 1, go CLEAR.
REQ-019 CLEAR: exactly 1 cycle, Eng_Rst_n=0, Eng_Active=0, In_Ready=0; then SHIFT with bit counter 0.
REQ-020 SHIFT: Eng_Active=1, Eng_Data = shift register bit 0 (LSB_FIRST=1) or bit 7 (LSB_FIRST=0); shift register and 3-bit bit counter advance each cycle; 8 cycles per byte.
REQ-021 SHIFT, bit counter 7, latched last=0: In_Ready=1; In_Valid=1 SHALL load next byte, increment byte count, wrap bit counter to 0 and stay in SHIFT with no gap cycle.
REQ-022 SHIFT, bit counter 7, latched last=0, In_Valid=0 (underrun): SHALL pulse Err next cycle, go IDLE, no CRC_Done, CRC_Out unchanged.
REQ-023 Loaded byte with byte count = MAX_BYTES and In_Last=0: SHALL be shifted normally, then at its bit counter 7 Err pulses and IDLE is entered as REQ-022 (In_Ready=0 at that point).
REQ-024 SHIFT, bit counter 7, latched last=1: In_Ready=0, go WAIT.
REQ-025 WAIT: exactly 1 cycle, Eng_Active=0 (engine moves LFSR bit 0 onto Eng_CRC); then CAPTURE.
REQ-026 CAPTURE: 8 cycles, Eng_Active=0; cycle k (0..7) SHALL sample Eng_CRC into CRC_Out bit k, assembled in a holding register and transferred to CRC_Out on entry to DONE.
REQ-027 DONE: 1 cycle, CRC_Done=1, CRC_Out valid, In_Ready=0; then IDLE.
REQ-028 Frame of N bytes: first acceptance to CRC_Done = 1 + 8N + 1 + 8 + 1 cycles; In_Valid during CLEAR/WAIT/CAPTURE/DONE SHALL be ignored (In_Ready=0).
REQ-029 Eng_Rst_n SHALL be 1 in all states except CLEAR and while Reset=1.

Reset
REQ-030 Reset=1 at an edge SHALL force IDLE from any state, clear counters, shift/holding registers, CRC_Out=0x00, CRC_Done=0, Err=0; no Err pulse for reset-aborted frame.
REQ-031 While Reset=1: Eng_Rst_n=0, Eng_Active=0, Eng_Data=0, In_Ready=0, Busy=0.

Verification
REQ-032 Single byte 0x00, In_Last=1 -> CLEAR 1 cycle, 8 SHIFT cycles Eng_Data=0, CRC_Out=0x00, CRC_Done 19 cycles after acceptance.
REQ-033 Frame 0xA5,0x3C,0xFF (last) back-to-back -> Eng_Data LSB-first sequence matches bytes, no gap, CRC_Out equals bit-accurate engine model, CRC_Done 35 cycles after first acceptance.
REQ-034 Two-byte frame, second In_Valid held low at first byte bit 7 -> Err pulse 1 cycle, IDLE, CRC_Done never asserted, CRC_Out retains previous value.
REQ-035 MAX_BYTES=2, three bytes none last -> third byte refused (In_Ready=0 at second byte bit 7), Err pulse, IDLE.
REQ-036 Reset=1 during CAPTURE cycle 4 -> next cycle IDLE, CRC_Out=0x00, Eng_Rst_n=0, no CRC_Done/Err; new frame 0x00 after release completes per REQ-032.
REQ-037 LSB_FIRST=0, byte 0x80 last -> Eng_Data=1 on first SHIFT cycle then 0 for 7 cycles, CRC_Out matches model.
